// File: rtl/rtc_alarm_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_alarm_ctrl_if
//  Function : Configuration and acknowledge bus for the RTC alarm controller.
//             The master writes alarm channels and acknowledges pending ones.
//  Revision : 1.0 - initial release
// ============================================================================
interface rtc_alarm_ctrl_if #(
  parameter int YEAR_W = 12,
  parameter int CH_W   = 2
);
  logic              cfg_we_i;
  logic [CH_W-1:0]   cfg_ch_i;
  logic [5:0]        cfg_sec_i;
  logic [5:0]        cfg_min_i;
  logic [5:0]        cfg_hour_i;
  logic [1:0]        cfg_mode_i;
  logic [2:0]        cfg_day_of_week_i;
  logic [4:0]        cfg_day_of_month_i;
  logic [3:0]        cfg_month_i;
  logic [YEAR_W-1:0] cfg_year_i;
  logic [7:0]        cfg_mask_i;
  logic              cfg_en_i;
  logic              cfg_periodic_i;
  logic              ack_i;
  logic [CH_W-1:0]   ack_ch_i;

  modport master (
    output cfg_we_i, cfg_ch_i, cfg_sec_i, cfg_min_i, cfg_hour_i, cfg_mode_i,
           cfg_day_of_week_i, cfg_day_of_month_i, cfg_month_i, cfg_year_i,
           cfg_mask_i, cfg_en_i, cfg_periodic_i, ack_i, ack_ch_i
  );

  modport slave (
    input  cfg_we_i, cfg_ch_i, cfg_sec_i, cfg_min_i, cfg_hour_i, cfg_mode_i,
           cfg_day_of_week_i, cfg_day_of_month_i, cfg_month_i, cfg_year_i,
           cfg_mask_i, cfg_en_i, cfg_periodic_i, ack_i, ack_ch_i
  );
endinterface
`default_nettype wire

// File: rtl/rtc_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_alarm_ctrl
//  Function : Multi-channel calendar alarm comparator. Each channel compares
//             the live RTC time against masked stored fields, fires on the
//             rising edge of a match and raises a sticky pending flag that
//             feeds a lowest-index-first interrupt request.
//  Revision : 1.0 - initial release
// ============================================================================
module rtc_alarm_ctrl #(
  parameter int NUM_CH = 4,
  parameter int YEAR_W = 12,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  input  wire logic [5:0]        cur_sec_i,
  input  wire logic [5:0]        cur_min_i,
  input  wire logic [5:0]        cur_hour_i,
  input  wire logic [1:0]        cur_mode_i,
  input  wire logic [2:0]        cur_day_of_week_i,
  input  wire logic [4:0]        cur_day_of_month_i,
  input  wire logic [3:0]        cur_month_i,
  input  wire logic [YEAR_W-1:0] cur_year_i,
  rtc_alarm_ctrl_if.slave        bus,
  input  wire logic              irq_en_i,
  output logic [NUM_CH-1:0]      pending_o,
  output logic [NUM_CH-1:0]      armed_o,
  output logic                   irq_o,
  output logic [CH_W-1:0]        irq_id_o
);

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_FIRED    = 2'd2;

  logic [NUM_CH-1:0] armed_w;
  logic [NUM_CH-1:0] pending_w;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [1:0]        state_q, state_d;
      logic              prev_match_q, prev_match_d;
      logic              periodic_q;
      logic [7:0]        mask_q;
      logic [5:0]        sec_q, min_q, hour_q;
      logic [1:0]        mode_q;
      logic [2:0]        dow_q;
      logic [4:0]        dom_q;
      logic [3:0]        month_q;
      logic [YEAR_W-1:0] year_q;
      logic [7:0]        eq;
      logic              match;
      logic              cfg_hit;
      logic              ack_hit;
      logic              fire;

      // Out-of-range channel indices never equal any i, so they are ignored.
      assign cfg_hit = bus.cfg_we_i && (bus.cfg_ch_i == CH_W'(i));
      assign ack_hit = bus.ack_i    && (bus.ack_ch_i == CH_W'(i));

      assign eq[0] = (cur_sec_i          == sec_q);
      assign eq[1] = (cur_min_i          == min_q);
      assign eq[2] = (cur_hour_i         == hour_q);
      assign eq[3] = (cur_mode_i         == mode_q);
      assign eq[4] = (cur_day_of_week_i  == dow_q);
      assign eq[5] = (cur_day_of_month_i == dom_q);
      assign eq[6] = (cur_month_i        == month_q);
      assign eq[7] = (cur_year_i         == year_q);

      // Unmasked fields read as equal, so an all-zero mask always matches.
      assign match = &(eq | ~mask_q);
      assign fire  = armed_w[i] && match && !prev_match_q;

      // Channel state register with configuration load.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          state_q      <= ST_DISABLED;
          prev_match_q <= 1'b0;
          periodic_q   <= 1'b0;
          mask_q       <= '0;
          sec_q        <= '0;
          min_q        <= '0;
          hour_q       <= '0;
          mode_q       <= '0;
          dow_q        <= '0;
          dom_q        <= '0;
          month_q      <= '0;
          year_q       <= '0;
        end else begin
          state_q      <= state_d;
          prev_match_q <= prev_match_d;
          if (cfg_hit) begin
            periodic_q <= bus.cfg_periodic_i;
            mask_q     <= bus.cfg_mask_i;
            sec_q      <= bus.cfg_sec_i;
            min_q      <= bus.cfg_min_i;
            hour_q     <= bus.cfg_hour_i;
            mode_q     <= bus.cfg_mode_i;
            dow_q      <= bus.cfg_day_of_week_i;
            dom_q      <= bus.cfg_day_of_month_i;
            month_q    <= bus.cfg_month_i;
            year_q     <= bus.cfg_year_i;
          end
        end
      end

      // Next state: a write overrides a fire, and a fire overrides an ack.
      always_comb begin
        state_d      = state_q;
        prev_match_d = match;
        if (cfg_hit) begin
          state_d      = bus.cfg_en_i ? ST_ARMED : ST_DISABLED;
          prev_match_d = 1'b0;
        end else if (fire) begin
          state_d = ST_FIRED;
        end else if (ack_hit && (state_q == ST_FIRED)) begin
          state_d = periodic_q ? ST_ARMED : ST_DISABLED;
        end
      end

      // A fired periodic channel stays armed so it can fire again.
      assign armed_w[i]   = (state_q == ST_ARMED) || ((state_q == ST_FIRED) && periodic_q);
      assign pending_w[i] = (state_q == ST_FIRED);
    end
  endgenerate

  // Output decode: flags, gated interrupt and lowest-index pending channel.
  always_comb begin
    armed_o   = armed_w;
    pending_o = pending_w;
    irq_o     = irq_en_i && (|pending_w);
    irq_id_o  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pending_w[k]) irq_id_o = CH_W'(k);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtc_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_alarm_ctrl
//  Function : Directed self-checking bench for rtc_alarm_ctrl (4 channels).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_alarm_ctrl;
  localparam int NUM_CH = 4;
  localparam int YEAR_W = 12;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [5:0]        cur_sec, cur_min, cur_hour;
  logic [1:0]        cur_mode;
  logic [2:0]        cur_dow;
  logic [4:0]        cur_dom;
  logic [3:0]        cur_month;
  logic [YEAR_W-1:0] cur_year;
  logic              irq_en;
  logic [NUM_CH-1:0] pending, armed;
  logic              irq;
  logic [CH_W-1:0]   irq_id;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_alarm_ctrl_if #(.YEAR_W(YEAR_W), .CH_W(CH_W)) bus ();

  rtc_alarm_ctrl #(.NUM_CH(NUM_CH), .YEAR_W(YEAR_W), .CH_W(CH_W)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .cur_sec_i          (cur_sec),
    .cur_min_i          (cur_min),
    .cur_hour_i         (cur_hour),
    .cur_mode_i         (cur_mode),
    .cur_day_of_week_i  (cur_dow),
    .cur_day_of_month_i (cur_dom),
    .cur_month_i        (cur_month),
    .cur_year_i         (cur_year),
    .bus                (bus.slave),
    .irq_en_i           (irq_en),
    .pending_o          (pending),
    .armed_o            (armed),
    .irq_o              (irq),
    .irq_id_o           (irq_id)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Place a configuration write on the bus (caller ticks).
  task automatic put_cfg(input int ch, input logic [5:0] sec, input logic [7:0] mask,
                         input logic en, input logic per, input logic [YEAR_W-1:0] year);
    bus.cfg_we_i           = 1'b1;
    bus.cfg_ch_i           = CH_W'(ch);
    bus.cfg_sec_i          = sec;
    bus.cfg_min_i          = '0;
    bus.cfg_hour_i         = '0;
    bus.cfg_mode_i         = '0;
    bus.cfg_day_of_week_i  = '0;
    bus.cfg_day_of_month_i = '0;
    bus.cfg_month_i        = '0;
    bus.cfg_year_i         = year;
    bus.cfg_mask_i         = mask;
    bus.cfg_en_i           = en;
    bus.cfg_periodic_i     = per;
  endtask

  task automatic cfg_write(input int ch, input logic [5:0] sec, input logic [7:0] mask,
                           input logic en, input logic per);
    put_cfg(ch, sec, mask, en, per, '0);
    tick();
    bus.cfg_we_i = 1'b0;
  endtask

  task automatic ack(input int ch);
    bus.ack_i    = 1'b1;
    bus.ack_ch_i = CH_W'(ch);
    tick();
    bus.ack_i    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    put_cfg(0, 6'd0, 8'h00, 1'b1, 1'b0, '0);
    bus.ack_i = 1'b1;
    tick();
    tick();
    n_checks++;
    if (armed !== 4'b0000) begin n_fail++; $display("FAIL reset_during armed got %b expected %b", armed, 4'b0000); end
    rst = 1'b0;
    bus.cfg_we_i = 1'b0;
    bus.ack_i = 1'b0;
    tick();
    n_checks++;
    if (pending !== 4'b0000 || armed !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got pend=%b armed=%b expected 0000/0000", pending, armed); end
    n_checks++;
    if (irq !== 1'b0 || irq_id !== 2'd0) begin n_fail++; $display("FAIL reset_irq got irq=%b id=%0d expected 0/0", irq, irq_id); end
  endtask

  task automatic test_oneshot();
    cur_sec = 6'd4;
    irq_en  = 1'b1;
    cfg_write(0, 6'd5, 8'h07, 1'b1, 1'b0);
    n_checks++;
    if (armed[0] !== 1'b1) begin n_fail++; $display("FAIL oneshot_armed got %b expected 1", armed[0]); end
    cur_sec = 6'd5;
    #1;
    n_checks++;
    if (pending[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_latency got %b expected 0", pending[0]); end
    tick();
    n_checks++;
    if (pending !== 4'b0001 || irq !== 1'b1 || irq_id !== 2'd0 || armed[0] !== 1'b0)
      begin n_fail++; $display("FAIL oneshot_fire got pend=%b irq=%b id=%0d armed0=%b expected 0001/1/0/0", pending, irq, irq_id, armed[0]); end
    ack(0);
    n_checks++;
    if (pending[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_ack got %b expected 0", pending[0]); end
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (pending[0] !== 1'b0 || armed[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_hold got pend=%b armed=%b expected 0/0", pending[0], armed[0]); end
  endtask

  task automatic test_periodic();
    cur_sec = 6'd29;
    cfg_write(1, 6'd30, 8'h01, 1'b1, 1'b1);
    cur_sec = 6'd30;
    tick();
    n_checks++;
    if (pending[1] !== 1'b1 || armed[1] !== 1'b1) begin n_fail++; $display("FAIL periodic_fire1 got pend=%b armed=%b expected 1/1", pending[1], armed[1]); end
    ack(1);
    n_checks++;
    if (pending[1] !== 1'b0 || armed[1] !== 1'b1) begin n_fail++; $display("FAIL periodic_ack got pend=%b armed=%b expected 0/1", pending[1], armed[1]); end
    cur_sec = 6'd29;
    tick();
    cur_sec = 6'd30;
    tick();
    n_checks++;
    if (pending[1] !== 1'b1 || armed[1] !== 1'b1) begin n_fail++; $display("FAIL periodic_fire2 got pend=%b armed=%b expected 1/1", pending[1], armed[1]); end
    cfg_write(1, 6'd0, 8'h01, 1'b0, 1'b0);
    n_checks++;
    if (pending[1] !== 1'b0 || armed[1] !== 1'b0) begin n_fail++; $display("FAIL periodic_cfg_clear got pend=%b armed=%b expected 0/0", pending[1], armed[1]); end
  endtask

  task automatic test_simultaneous();
    cur_sec = 6'd39;
    cfg_write(2, 6'd40, 8'h01, 1'b1, 1'b0);
    cfg_write(3, 6'd40, 8'h01, 1'b1, 1'b0);
    cur_sec = 6'd40;
    tick();
    n_checks++;
    if (pending !== 4'b1100 || irq_id !== 2'd2 || irq !== 1'b1) begin n_fail++; $display("FAIL simul_fire got pend=%b id=%0d irq=%b expected 1100/2/1", pending, irq_id, irq); end
    ack(2);
    n_checks++;
    if (pending !== 4'b1000 || irq_id !== 2'd3) begin n_fail++; $display("FAIL simul_ack2 got pend=%b id=%0d expected 1000/3", pending, irq_id); end
    ack(3);
    n_checks++;
    if (irq !== 1'b0 || irq_id !== 2'd0) begin n_fail++; $display("FAIL simul_ack3 got irq=%b id=%0d expected 0/0", irq, irq_id); end
  endtask

  task automatic test_fire_ack_same();
    cur_sec = 6'd10;
    cfg_write(0, 6'd11, 8'h01, 1'b1, 1'b0);
    cur_sec = 6'd11;
    ack(0);
    n_checks++;
    if (pending[0] !== 1'b1) begin n_fail++; $display("FAIL fire_vs_ack got %b expected 1", pending[0]); end
    ack(0);
    n_checks++;
    if (pending[0] !== 1'b0) begin n_fail++; $display("FAIL fire_vs_ack_clear got %b expected 0", pending[0]); end
  endtask

  task automatic test_write_wins();
    cur_sec = 6'd49;
    cfg_write(1, 6'd50, 8'h01, 1'b1, 1'b1);
    cur_sec = 6'd50;
    cfg_write(1, 6'd50, 8'h01, 1'b0, 1'b1);
    n_checks++;
    if (pending[1] !== 1'b0 || armed[1] !== 1'b0) begin n_fail++; $display("FAIL write_vs_fire got pend=%b armed=%b expected 0/0", pending[1], armed[1]); end
  endtask

  task automatic test_cfg_and_ack();
    cur_sec = 6'd19;
    cfg_write(0, 6'd20, 8'h01, 1'b1, 1'b0);
    cur_sec = 6'd20;
    tick();
    put_cfg(2, 6'd55, 8'h01, 1'b1, 1'b0, '0);
    bus.ack_i    = 1'b1;
    bus.ack_ch_i = 2'd0;
    tick();
    bus.cfg_we_i = 1'b0;
    bus.ack_i    = 1'b0;
    n_checks++;
    if (pending[0] !== 1'b0 || armed[2] !== 1'b1) begin n_fail++; $display("FAIL cfg_and_ack got pend0=%b armed2=%b expected 0/1", pending[0], armed[2]); end
    cfg_write(2, 6'd0, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_mask_zero_and_year();
    cfg_write(3, 6'd0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (pending[3] !== 1'b0 || armed[3] !== 1'b1) begin n_fail++; $display("FAIL mask0_armed got pend=%b armed=%b expected 0/1", pending[3], armed[3]); end
    tick();
    n_checks++;
    if (pending[3] !== 1'b1) begin n_fail++; $display("FAIL mask0_fire got %b expected 1", pending[3]); end
    ack(3);
    cur_year = 12'd2023;
    put_cfg(2, 6'd0, 8'h80, 1'b1, 1'b0, 12'd2024);
    tick();
    bus.cfg_we_i = 1'b0;
    tick();
    n_checks++;
    if (pending[2] !== 1'b0) begin n_fail++; $display("FAIL year_nomatch got %b expected 0", pending[2]); end
    cur_year = 12'd2024;
    tick();
    n_checks++;
    if (pending !== 4'b0100 || irq_id !== 2'd2) begin n_fail++; $display("FAIL year_fire got pend=%b id=%0d expected 0100/2", pending, irq_id); end
    ack(2);
  endtask

  task automatic test_irq_gate();
    irq_en  = 1'b0;
    cur_sec = 6'd24;
    cfg_write(0, 6'd25, 8'h01, 1'b1, 1'b0);
    cur_sec = 6'd25;
    tick();
    n_checks++;
    if (pending[0] !== 1'b1 || irq !== 1'b0) begin n_fail++; $display("FAIL irq_gated got pend=%b irq=%b expected 1/0", pending[0], irq); end
    irq_en = 1'b1;
    #1;
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_ungate got %b expected 1", irq); end
    ack(0);
  endtask

  task automatic test_reset_mid();
    cur_sec = 6'd32;
    cfg_write(0, 6'd33, 8'h01, 1'b1, 1'b0);
    cfg_write(1, 6'd33, 8'h01, 1'b1, 1'b1);
    cur_sec = 6'd33;
    tick();
    n_checks++;
    if (pending !== 4'b0011) begin n_fail++; $display("FAIL rstmid_setup got %b expected 0011", pending); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (pending !== 4'b0000 || armed !== 4'b0000 || irq !== 1'b0 || irq_id !== 2'd0)
      begin n_fail++; $display("FAIL rstmid_clear got pend=%b armed=%b irq=%b id=%0d expected all 0", pending, armed, irq, irq_id); end
    cur_sec = 6'd32;
    tick();
    cur_sec = 6'd33;
    tick();
    tick();
    n_checks++;
    if (pending !== 4'b0000) begin n_fail++; $display("FAIL rstmid_nofire got %b expected 0000", pending); end
  endtask

  initial begin
    rst = 1'b1;
    cur_sec = '0; cur_min = '0; cur_hour = '0; cur_mode = '0;
    cur_dow = '0; cur_dom = '0; cur_month = '0; cur_year = '0;
    irq_en = 1'b0;
    put_cfg(0, 6'd0, 8'h00, 1'b0, 1'b0, '0);
    bus.cfg_we_i = 1'b0;
    bus.ack_i    = 1'b0;
    bus.ack_ch_i = '0;

    test_reset();
    test_oneshot();
    test_periodic();
    test_simultaneous();
    test_fire_ack_same();
    test_write_wins();
    test_cfg_and_ack();
    test_mask_zero_and_year();
    test_irq_gate();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rtc_alarm_ctrl.md
RTC_ALARM_CTRL -- requirements
Module: rtc_alarm_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent alarm channels (1..16).
REQ-002 Parameter YEAR_W, default 12, width of year field.
REQ-003 Parameter CH_W, default $clog2(NUM_CH) (minimum 1), channel index width.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 cur_sec_i/cur_min_i/cur_hour_i  in  6 each  current time from RTC core.
REQ-007 cur_mode_i  in  2; cur_day_of_week_i  in  3; cur_day_of_month_i  in  5; cur_month_i  in  4; cur_year_i  in  YEAR_W.
REQ-008 cfg_we_i  in  1  one-cycle write strobe for channel configuration.
REQ-009 cfg_ch_i  in  CH_W  channel being written.
REQ-010 cfg_sec_i..cfg_year_i  in  same widths as cur_*  alarm compare values.
REQ-011 cfg_mask_i  in  8  per-field compare enable, bit order [0]=sec,[1]=min,[2]=hour,[3]=mode,[4]=dow,[5]=dom,[6]=month,[7]=year.
REQ-012 cfg_en_i  in  1  channel armed after write; cfg_periodic_i  in  1  1=re-arm after fire, 0=one-shot.
REQ-013 ack_i  in  1  acknowledge strobe; ack_ch_i  in  CH_W  channel acknowledged.
REQ-014 irq_en_i  in  1  global interrupt gate.
REQ-015 pending_o  out  NUM_CH  sticky per-channel pending flags.
REQ-016 armed_o  out  NUM_CH  per-channel armed flags.
REQ-017 irq_o  out  1  interrupt request; irq_id_o  out  CH_W  lowest-numbered pending channel.

Function
REQ-018 Channel match = AND over fields with mask bit 1 of (cur field == stored field); mask 8'h00 matches unconditionally.
REQ-019 Per channel registered prev_match; fire = armed & match & ~prev_match (rising edge only; a held time value fires once).
REQ-020 Per-channel FSM: DISABLED (armed=0,pending=0), ARMED (armed=1,pending=0), FIRED (pending=1, armed=periodic).
REQ-021 ARMED->FIRED on fire; pending_o bit sets on the clock edge after the matching cycle (latency 1).
REQ-022 One-shot channel clears armed on fire; periodic channel keeps armed and may fire again while pending (pending stays 1, no counting).
REQ-023 FIRED->ARMED (periodic) or ->DISABLED (one-shot) on ack_i with ack_ch_i equal to channel.
REQ-024 Fire and ack on same channel same cycle: fire wins, pending remains 1.
REQ-025 cfg_we_i loads fields, mask, periodic, armed=cfg_en_i; clears that channel's pending and prev_match next edge.
REQ-026 cfg_we_i and fire on the same channel same cycle: write wins, no pending set.
REQ-027 cfg_we_i and ack_i to different channels same cycle: both take effect.
REQ-028 cfg_ch_i or ack_ch_i >= NUM_CH: strobe ignored, no state change.
REQ-029 irq_o = irq_en_i & |pending_o, combinational from registers; irq_en_i does not gate pending setting.
REQ-030 irq_id_o = index of lowest set pending_o bit; 0 when none pending.
REQ-031 Channels operate independently; multiple channels may fire in one cycle.

Reset
REQ-032 rst_i high at a rising edge: all stored fields, masks, periodic, armed, pending, prev_match cleared to 0.
REQ-033 During and after reset: pending_o=0, armed_o=0, irq_o=0, irq_id_o=0; strobes during reset ignored.
REQ-034 Reset mid-operation discards pending interrupts with no further fire until reprogrammed.

Verification
REQ-035 Ch0 cfg 00:00:05, mask 8'h07, one-shot, en=1, irq_en=1; cur_sec 4->5 -> pending_o[0]=1 one cycle later, irq_o=1, irq_id_o=0, armed_o[0]=0; hold sec=5 ten cycles -> no re-fire.
REQ-036 Ch1 periodic mask 8'h01 sec=30; ack after fire; sec 29->30 -> fire again; armed_o[1] stays 1 throughout.
REQ-037 Ch2 and ch3 fire same cycle -> pending_o=4'b1100, irq_id_o=2; ack ch2 -> irq_id_o=3; ack ch3 -> irq_o=0.
REQ-038 Ack ch0 in the cycle ch0 fires -> pending_o[0]=1 after the edge.
REQ-039 irq_en_i=0 during fire -> pending_o[0]=1, irq_o=0; irq_en_i->1 -> irq_o=1 same cycle.
REQ-040 rst_i pulsed while pending_o=4'b0011 -> all outputs 0 next edge; matching time afterward produces no fire.
